// File: rtl/pll_seq_pkg.sv
// Shared types and sizing helper for the PLL bring-up sequencer.
package pll_seq_pkg;

    typedef enum logic [2:0] {
        PLLRST    = 3'd0,
        WAIT_LOCK = 3'd1,
        STABLE    = 3'd2,
        RUN       = 3'd3,
        ADJUST    = 3'd4,
        FAIL      = 3'd5
    } seq_state_t;

    // Width of the shared phase counter; it only ever counts to (largest period - 1).
    function automatic int cnt_width(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return (m < 2) ? 1 : $clog2(m);
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Generic two-flop synchronizer for bringing asynchronous levels into the clk domain.
module sync_2ff #(
    parameter int WIDTH = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            meta <= '0;
            q    <= '0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/pll_lock_sequencer.sv
// rPLL bring-up sequencer: reset pulse, lock wait with retry, lock qualification,
// downstream reset release and req/ack reconfiguration of PSDA/DUTYDA.
module pll_lock_sequencer
    import pll_seq_pkg::*;
#(
    parameter int         RST_CYCLES    = 16,
    parameter int         LOCK_TIMEOUT  = 50000,
    parameter int         STABLE_CYCLES = 1024,
    parameter int         SETTLE_CYCLES = 256,
    parameter int         MAX_RETRIES   = 7,
    parameter logic [3:0] INIT_PSDA     = 4'h0,
    parameter logic [3:0] INIT_DUTYDA   = 4'h8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       lock,
    input  logic       cfg_req,
    input  logic [3:0] cfg_psda,
    input  logic [3:0] cfg_dutyda,
    output logic       cfg_ack,
    output logic       pll_reset,
    output logic [3:0] psda,
    output logic [3:0] dutyda,
    output logic       sys_reset,
    output logic       ready,
    output logic       fail,
    output logic [2:0] retries
);

    localparam int CW = cnt_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES, SETTLE_CYCLES);

    localparam logic [CW-1:0] RST_LAST    = CW'(RST_CYCLES - 1);
    localparam logic [CW-1:0] TO_LAST     = CW'(LOCK_TIMEOUT - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] SETTLE_LAST = CW'(SETTLE_CYCLES - 1);
    localparam logic [2:0]    MAX_R       = 3'(MAX_RETRIES);

    seq_state_t    state, next_state;
    logic [CW-1:0] cnt, cnt_next;
    logic          lock_s;
    logic          timeout;
    logic          take_cfg;
    logic          ready_q;
    logic          cfg_ack_q;
    logic [2:0]    retries_q;
    logic [3:0]    psda_q, dutyda_q;

    sync_2ff #(.WIDTH(1)) u_lock_sync (
        .clk   (clk),
        .reset (reset),
        .d     (lock),
        .q     (lock_s)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= PLLRST;
            cnt       <= '0;
            ready_q   <= 1'b0;
            cfg_ack_q <= 1'b0;
            retries_q <= 3'd0;
            psda_q    <= INIT_PSDA;
            dutyda_q  <= INIT_DUTYDA;
        end else begin
            state     <= next_state;
            cnt       <= cnt_next;
            ready_q   <= (next_state == RUN);
            cfg_ack_q <= take_cfg;
            if (timeout && retries_q != MAX_R)
                retries_q <= retries_q + 3'd1;
            else if (state == STABLE && next_state == RUN)
                retries_q <= 3'd0;
            if (take_cfg) begin
                psda_q   <= cfg_psda;
                dutyda_q <= cfg_dutyda;
            end
        end
    end

    // Loss of lock is checked ahead of cfg_req in RUN so it always wins the cycle.
    always_comb begin
        next_state = state;
        timeout    = 1'b0;
        take_cfg   = 1'b0;
        unique case (state)
            PLLRST:    if (cnt == RST_LAST) next_state = WAIT_LOCK;
            WAIT_LOCK: begin
                if (lock_s) begin
                    next_state = STABLE;
                end else if (cnt == TO_LAST) begin
                    timeout    = 1'b1;
                    next_state = (retries_q + 3'd1 == MAX_R) ? FAIL : PLLRST;
                end
            end
            STABLE: begin
                if (!lock_s)                 next_state = WAIT_LOCK;
                else if (cnt == STABLE_LAST) next_state = RUN;
            end
            RUN: begin
                if (!lock_s) begin
                    next_state = WAIT_LOCK;
                end else if (cfg_req) begin
                    take_cfg   = 1'b1;
                    next_state = ADJUST;
                end
            end
            ADJUST:    if (cnt == SETTLE_LAST) next_state = STABLE;
            FAIL:      next_state = FAIL;
            default:   next_state = PLLRST;
        endcase

        if (next_state != state || state == RUN || state == FAIL)
            cnt_next = '0;
        else
            cnt_next = cnt + 1'b1;
    end

    always_comb begin
        pll_reset = (state == PLLRST) || (state == FAIL);
        fail      = (state == FAIL);
        ready     = ready_q;
        sys_reset = ~ready_q;
        cfg_ack   = cfg_ack_q;
        retries   = retries_q;
        psda      = psda_q;
        dutyda    = dutyda_q;
    end

endmodule

// File: tb/tb_pll_lock_sequencer.sv
// Directed bench for pll_lock_sequencer with shortened timing parameters.
module tb_pll_lock_sequencer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       lock = 1'b0;
    logic       cfg_req = 1'b0;
    logic [3:0] cfg_psda = 4'h0;
    logic [3:0] cfg_dutyda = 4'h0;
    logic       cfg_ack, pll_reset, sys_reset, ready, fail;
    logic [3:0] psda, dutyda;
    logic [2:0] retries;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    pll_lock_sequencer #(
        .RST_CYCLES    (4),
        .LOCK_TIMEOUT  (100),
        .STABLE_CYCLES (16),
        .SETTLE_CYCLES (8),
        .MAX_RETRIES   (3),
        .INIT_PSDA     (4'h0),
        .INIT_DUTYDA   (4'h8)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .lock       (lock),
        .cfg_req    (cfg_req),
        .cfg_psda   (cfg_psda),
        .cfg_dutyda (cfg_dutyda),
        .cfg_ack    (cfg_ack),
        .pll_reset  (pll_reset),
        .psda       (psda),
        .dutyda     (dutyda),
        .sys_reset  (sys_reset),
        .ready      (ready),
        .fail       (fail),
        .retries    (retries)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        int n;
        lock = 1'b0;
        cfg_req = 1'b0;
        do_reset();
        checks++; if (pll_reset !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL reset_ctl pll_reset=%b sys_reset=%b ready=%b want 1 1 0", pll_reset, sys_reset, ready);
        end
        checks++; if (fail !== 1'b0 || retries !== 3'd0 || cfg_ack !== 1'b0) begin
            errors++; $display("FAIL reset_status fail=%b retries=%0d cfg_ack=%b want 0 0 0", fail, retries, cfg_ack);
        end
        checks++; if (psda !== 4'h0 || dutyda !== 4'h8) begin
            errors++; $display("FAIL reset_cfg psda=%h dutyda=%h want 0 8", psda, dutyda);
        end
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin n++; tick(); end
        checks++; if (n !== 4) begin
            errors++; $display("FAIL reset_pulse_width got %0d want 4", n);
        end
    endtask

    task automatic test_normal();
        int n;
        repeat (10) tick();
        lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 19) begin
            errors++; $display("FAIL normal_ready_latency got %0d want 19", n);
        end
        checks++; if (sys_reset !== 1'b0 || retries !== 3'd0 || pll_reset !== 1'b0) begin
            errors++; $display("FAIL normal_run sys_reset=%b retries=%0d pll_reset=%b want 0 0 0", sys_reset, retries, pll_reset);
        end
    endtask

    task automatic test_config();
        int n;
        cfg_psda = 4'h5;
        cfg_dutyda = 4'h4;
        cfg_req = 1'b1;
        tick();
        checks++; if (cfg_ack !== 1'b1 || psda !== 4'h5 || dutyda !== 4'h4) begin
            errors++; $display("FAIL cfg_accept ack=%b psda=%h dutyda=%h want 1 5 4", cfg_ack, psda, dutyda);
        end
        checks++; if (sys_reset !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL cfg_hold sys_reset=%b ready=%b want 1 0", sys_reset, ready);
        end
        cfg_req = 1'b0;
        tick();
        checks++; if (cfg_ack !== 1'b0) begin
            errors++; $display("FAIL cfg_ack_pulse ack=%b want 0", cfg_ack);
        end
        n = 2;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 25) begin
            errors++; $display("FAIL cfg_ready_latency got %0d want 25", n);
        end
    endtask

    task automatic test_lock_loss();
        int n;
        logic saw_prst;
        saw_prst = 1'b0;
        lock = 1'b0;
        n = 0;
        while (sys_reset !== 1'b1 && n < 20) begin tick(); n++; if (pll_reset) saw_prst = 1'b1; end
        checks++; if (n !== 3 || ready !== 1'b0) begin
            errors++; $display("FAIL loss_latency got %0d ready=%b want 3 0", n, ready);
        end
        lock = 1'b1;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; if (pll_reset) saw_prst = 1'b1; end
        checks++; if (n !== 19) begin
            errors++; $display("FAIL relock_latency got %0d want 19", n);
        end
        checks++; if (saw_prst !== 1'b0 || retries !== 3'd0) begin
            errors++; $display("FAIL loss_no_retry pll_pulse=%b retries=%0d want 0 0", saw_prst, retries);
        end
    endtask

    task automatic test_loss_vs_cfg();
        int n;
        lock = 1'b0;
        tick();
        tick();
        cfg_psda = 4'h9;
        cfg_dutyda = 4'h2;
        cfg_req = 1'b1;
        tick();
        checks++; if (cfg_ack !== 1'b0 || sys_reset !== 1'b1 || psda !== 4'h5) begin
            errors++; $display("FAIL loss_wins ack=%b sys_reset=%b psda=%h want 0 1 5", cfg_ack, sys_reset, psda);
        end
        lock = 1'b1;
        n = 0;
        while (cfg_ack !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 20 || psda !== 4'h9 || dutyda !== 4'h2) begin
            errors++; $display("FAIL loss_cfg_pending n=%0d psda=%h dutyda=%h want 20 9 2", n, psda, dutyda);
        end
        cfg_req = 1'b0;
    endtask

    task automatic test_glitch();
        int n;
        logic saw_prst;
        lock = 1'b0;
        do_reset();
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin tick(); n++; end
        lock = 1'b1;
        repeat (11) tick();
        lock = 1'b0;
        tick();
        lock = 1'b1;
        saw_prst = 1'b0;
        n = 0;
        while (ready !== 1'b1 && n < 100) begin tick(); n++; if (pll_reset) saw_prst = 1'b1; end
        checks++; if (n !== 19) begin
            errors++; $display("FAIL glitch_ready_latency got %0d want 19", n);
        end
        checks++; if (saw_prst !== 1'b0 || retries !== 3'd0) begin
            errors++; $display("FAIL glitch_no_retry pll_pulse=%b retries=%0d want 0 0", saw_prst, retries);
        end
    endtask

    task automatic test_timeout();
        int hi, lo;
        lock = 1'b0;
        do_reset();
        for (int p = 0; p < 3; p++) begin
            hi = 0;
            while (pll_reset === 1'b1 && hi < 50) begin hi++; tick(); end
            checks++; if (hi !== 4) begin
                errors++; $display("FAIL timeout_pulse%0d width got %0d want 4", p, hi);
            end
            lo = 0;
            while (pll_reset === 1'b0 && lo < 300) begin lo++; tick(); end
            checks++; if (lo !== 100) begin
                errors++; $display("FAIL timeout_wait%0d got %0d want 100", p, lo);
            end
            checks++; if (retries !== 3'(p + 1) || fail !== (p == 2)) begin
                errors++; $display("FAIL timeout_retry%0d retries=%0d fail=%b want %0d %b", p, retries, fail, p + 1, (p == 2));
            end
        end
        repeat (5) tick();
        checks++; if (fail !== 1'b1 || pll_reset !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0 || retries !== 3'd3) begin
            errors++; $display("FAIL fail_sticky fail=%b pll_reset=%b sys_reset=%b ready=%b retries=%0d want 1 1 1 0 3",
                               fail, pll_reset, sys_reset, ready, retries);
        end
    endtask

    task automatic test_pending_cfg();
        int n;
        lock = 1'b0;
        do_reset();
        n = 0;
        while (pll_reset === 1'b1 && n < 50) begin tick(); n++; end
        checks++; if (fail !== 1'b0 || retries !== 3'd0) begin
            errors++; $display("FAIL fail_cleared fail=%b retries=%0d want 0 0", fail, retries);
        end
        cfg_psda = 4'h3;
        cfg_dutyda = 4'h7;
        cfg_req = 1'b1;
        repeat (5) tick();
        checks++; if (cfg_ack !== 1'b0 || psda !== 4'h0) begin
            errors++; $display("FAIL pending_no_ack ack=%b psda=%h want 0 0", cfg_ack, psda);
        end
        lock = 1'b1;
        n = 0;
        while (cfg_ack !== 1'b1 && n < 100) begin tick(); n++; end
        checks++; if (n !== 20 || psda !== 4'h3 || dutyda !== 4'h7) begin
            errors++; $display("FAIL pending_ack n=%0d psda=%h dutyda=%h want 20 3 7", n, psda, dutyda);
        end
        cfg_req = 1'b0;
    endtask

    task automatic test_reset_mid_adjust();
        repeat (3) tick();
        checks++; if (sys_reset !== 1'b1 || ready !== 1'b0) begin
            errors++; $display("FAIL adjust_hold sys_reset=%b ready=%b want 1 0", sys_reset, ready);
        end
        reset = 1'b1;
        tick();
        checks++; if (psda !== 4'h0 || dutyda !== 4'h8) begin
            errors++; $display("FAIL midreset_cfg psda=%h dutyda=%h want 0 8", psda, dutyda);
        end
        checks++; if (pll_reset !== 1'b1 || sys_reset !== 1'b1 || ready !== 1'b0 || cfg_ack !== 1'b0) begin
            errors++; $display("FAIL midreset_ctl pll_reset=%b sys_reset=%b ready=%b ack=%b want 1 1 0 0",
                               pll_reset, sys_reset, ready, cfg_ack);
        end
        reset = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_normal();
        test_config();
        test_lock_loss();
        test_loss_vs_cfg();
        test_glitch();
        test_timeout();
        test_pending_cfg();
        test_reset_mid_adjust();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
